mem_access_unit: RTL and testbench

- Pipeline-side initiator for the data RAM: turns the MEM-stage load/store request into the RAM's `ce`/`we`/`sel`/`addr`/`data` transaction.
- Holds the pipeline until the access completes, then returns size-aligned, sign- or zero-extended load data.
- Sits between the MEM stage and the word-organised, four-byte-lane data RAM; all RAM-facing outputs are registered.

---
 rtl/mem_access_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage initiator for the four-lane data RAM; stalls the
//            pipeline and returns extended load data. Optional macro
//            ADDR_ALIGN_CHECK_EN enables the misaligned-access trap.
// Revision : 1.0
// ============================================================================

package mem_access_unit_pkg;
    typedef enum logic {
        CHIP_DISABLE = 1'b0,
        CHIP_ENABLE  = 1'b1
    } chip_en_t;
    typedef logic [31:0] ram_addr_t;
    typedef logic [31:0] ram_data_t;
endpackage

module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int RAM_LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req_i,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        stall_o,
    output logic        load_valid_o,
    output logic [31:0] load_data_o,
    output logic        addr_err_o,
    output logic [31:0] badvaddr_o,
    output chip_en_t    ram_ce_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    output ram_addr_t   ram_addr_o,
    output ram_data_t   ram_data_o,
    input  ram_data_t   ram_data_i
);

    localparam logic [2:0] c_op_lb  = 3'd0;
    localparam logic [2:0] c_op_lbu = 3'd1;
    localparam logic [2:0] c_op_lh  = 3'd2;
    localparam logic [2:0] c_op_lhu = 3'd3;
    localparam logic [2:0] c_op_lw  = 3'd4;
    localparam logic [2:0] c_op_sb  = 3'd5;
    localparam logic [2:0] c_op_sh  = 3'd6;
    localparam logic [2:0] c_op_sw  = 3'd7;

    localparam logic [2:0] c_wait_init = 3'(RAM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_wait_cnt;
    logic [2:0]  r_op;
    logic [1:0]  r_off;

    logic        w_req_store;
    logic        w_cur_store;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [31:0] w_load_ext;

    function automatic logic is_store(input logic [2:0] op);
        return op[2] & (op[1] | op[0]);
    endfunction

    assign w_req_store = is_store(mem_op_i);
    assign w_cur_store = is_store(r_op);

    // Big-endian lanes: byte offset k lives in sel[3-k] / bits 31-8k.
    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = mem_wdata_i;
        case (mem_op_i)
            c_op_lb, c_op_lbu, c_op_sb: begin
                w_sel   = 4'b1000 >> mem_addr_i[1:0];
                w_wdata = {4{mem_wdata_i[7:0]}};
            end
            c_op_lh, c_op_lhu, c_op_sh: begin
                w_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{mem_wdata_i[15:0]}};
            end
            default: begin
                w_sel   = 4'b1111;
                w_wdata = mem_wdata_i;
            end
        endcase
    end

    always_comb begin
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        case (r_off)
            2'd0:    v_byte = ram_data_i[31:24];
            2'd1:    v_byte = ram_data_i[23:16];
            2'd2:    v_byte = ram_data_i[15:8];
            default: v_byte = ram_data_i[7:0];
        endcase
        v_half = r_off[1] ? ram_data_i[15:0] : ram_data_i[31:16];
        case (r_op)
            c_op_lb:  w_load_ext = {{24{v_byte[7]}}, v_byte};
            c_op_lbu: w_load_ext = {24'd0, v_byte};
            c_op_lh:  w_load_ext = {{16{v_half[15]}}, v_half};
            c_op_lhu: w_load_ext = {16'd0, v_half};
            default:  w_load_ext = ram_data_i;
        endcase
    end

`ifdef ADDR_ALIGN_CHECK_EN
    logic        r_addr_err;
    logic [31:0] r_badvaddr;
    logic        w_misaligned;

    always_comb begin
        w_misaligned = 1'b0;
        case (mem_op_i)
            c_op_lh, c_op_lhu, c_op_sh: w_misaligned = mem_addr_i[0];
            c_op_lw, c_op_sw:           w_misaligned = (mem_addr_i[1:0] != 2'b00);
            default:                    w_misaligned = 1'b0;
        endcase
    end

    assign addr_err_o = r_addr_err;
    assign badvaddr_o = r_badvaddr;
`else
    assign addr_err_o = 1'b0;
    assign badvaddr_o = 32'd0;
`endif

    // Gated by rst_n so the pipeline is released while reset is held.
    assign stall_o = rst_n & ((r_state == ACCESS) || (r_state == WAIT) ||
                              ((r_state == IDLE) && mem_req_i));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wait_cnt   <= 3'd0;
            r_op         <= 3'd0;
            r_off        <= 2'd0;
            ram_ce_o     <= CHIP_DISABLE;
            ram_we_o     <= 1'b0;
            ram_sel_o    <= 4'd0;
            ram_addr_o   <= '0;
            ram_data_o   <= '0;
            load_valid_o <= 1'b0;
            load_data_o  <= 32'd0;
`ifdef ADDR_ALIGN_CHECK_EN
            r_addr_err   <= 1'b0;
            r_badvaddr   <= 32'd0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (mem_req_i) begin
                        r_op  <= mem_op_i;
                        r_off <= mem_addr_i[1:0];
`ifdef ADDR_ALIGN_CHECK_EN
                        if (w_misaligned) begin
                            r_state    <= DONE;
                            r_addr_err <= 1'b1;
                            r_badvaddr <= mem_addr_i;
                        end else
`endif
                        begin
                            r_state    <= ACCESS;
                            ram_ce_o   <= CHIP_ENABLE;
                            ram_we_o   <= w_req_store;
                            ram_sel_o  <= w_sel;
                            ram_addr_o <= {mem_addr_i[31:2], 2'b00};
                            ram_data_o <= w_wdata;
                        end
                    end
                end
                ACCESS: begin
                    ram_we_o <= 1'b0;
                    if (w_cur_store || (RAM_LATENCY == 0)) begin
                        r_state   <= DONE;
                        ram_ce_o  <= CHIP_DISABLE;
                        ram_sel_o <= 4'd0;
                        if (!w_cur_store) begin
                            load_valid_o <= 1'b1;
                            load_data_o  <= w_load_ext;
                        end
                    end else begin
                        r_state    <= WAIT;
                        r_wait_cnt <= c_wait_init;
                    end
                end
                WAIT: begin
                    if (r_wait_cnt == 3'd0) begin
                        r_state      <= DONE;
                        ram_ce_o     <= CHIP_DISABLE;
                        ram_sel_o    <= 4'd0;
                        load_valid_o <= 1'b1;
                        load_data_o  <= w_load_ext;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    load_valid_o <= 1'b0;
`ifdef ADDR_ALIGN_CHECK_EN
                    r_addr_err   <= 1'b0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench; two DUTs (RAM_LATENCY 0 and 3) against a
//            byte-addressed big-endian memory model. Honours ADDR_ALIGN_CHECK_EN.
// Revision : 1.0
// ============================================================================

module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req   [2];
    logic [2:0]  op    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        stall [2];
    logic        lvalid[2];
    logic [31:0] ldata [2];
    logic        aerr  [2];
    logic [31:0] bva   [2];
    chip_en_t    ce    [2];
    logic        we    [2];
    logic [3:0]  sel   [2];
    ram_addr_t   raddr [2];
    ram_data_t   rdo   [2];
    ram_data_t   rdi   [2];

    int ncmp = 0;
    int nerr = 0;
    logic [7:0] bmem [2][1024];

    function automatic int lat(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] init_word(input int d, input int i);
        return (i * 32'h9E3779B1) ^ (d * 32'h5A5A0F0F) ^ 32'h1234_5678;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 0 : 3;
        logic [31:0] mem [256];
        int  cnt;
        bit  inited;
        // RAM presents valid data only in the cycle exactly L cycles after ACCESS.
        always @(posedge clk) begin
            if (!inited) begin
                for (int i = 0; i < 256; i++) mem[i] <= init_word(g, i);
                inited <= 1'b1;
            end
            cnt <= (ce[g] == CHIP_ENABLE) ? cnt + 1 : 0;
            if (ce[g] == CHIP_ENABLE && we[g])
                for (int k = 0; k < 4; k++)
                    if (sel[g][k]) mem[raddr[g][9:2]][8*k +: 8] <= rdo[g][8*k +: 8];
        end
        assign rdi[g] = (ce[g] == CHIP_ENABLE && cnt == L) ? mem[raddr[g][9:2]] : 32'hDEAD_BEEF;

        mem_access_unit #(.RAM_LATENCY(L)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .mem_req_i    (req[g]),
            .mem_op_i     (op[g]),
            .mem_addr_i   (addr[g]),
            .mem_wdata_i  (wdata[g]),
            .stall_o      (stall[g]),
            .load_valid_o (lvalid[g]),
            .load_data_o  (ldata[g]),
            .addr_err_o   (aerr[g]),
            .badvaddr_o   (bva[g]),
            .ram_ce_o     (ce[g]),
            .ram_we_o     (we[g]),
            .ram_sel_o    (sel[g]),
            .ram_addr_o   (raddr[g]),
            .ram_data_o   (rdo[g]),
            .ram_data_i   (rdi[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] o);
        if (o == 3'd0 || o == 3'd1 || o == 3'd5) return 1;
        if (o == 3'd2 || o == 3'd3 || o == 3'd6) return 2;
        return 4;
    endfunction

    function automatic bit misaligned(input logic [2:0] o, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(o)) != 0;
    endfunction

    function automatic logic [31:0] exp_load(input int d, input logic [2:0] o, input logic [31:0] a);
        int i;
        int h;
        int w;
        i = int'(a[9:0]);
        h = i & ~1;
        w = i & ~3;
        case (o)
            3'd0:    return {{24{bmem[d][i][7]}}, bmem[d][i]};
            3'd1:    return {24'd0, bmem[d][i]};
            3'd2:    return {{16{bmem[d][h][7]}}, bmem[d][h], bmem[d][h+1]};
            3'd3:    return {16'd0, bmem[d][h], bmem[d][h+1]};
            default: return {bmem[d][w], bmem[d][w+1], bmem[d][w+2], bmem[d][w+3]};
        endcase
    endfunction

    function automatic logic [3:0] exp_sel(input logic [2:0] o, input logic [31:0] a);
        int n;
        int base;
        logic [3:0] s;
        n = nbytes(o);
        base = int'(a[1:0]) & ~(n - 1);
        s = 4'd0;
        for (int j = 0; j < n; j++) s[3 - (base + j)] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] exp_rdo(input logic [2:0] o, input logic [31:0] wd);
        case (nbytes(o))
            1:       return {4{wd[7:0]}};
            2:       return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    task automatic model_store(input int d, input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd);
        int n;
        int base;
        logic [31:0] v;
        n = nbytes(o);
        base = int'(a[9:0]) & ~(n - 1);
        for (int j = 0; j < n; j++) begin
            v = wd >> (8 * (n - 1 - j));
            bmem[d][base + j] = v[7:0];
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic do_txn(input int d, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] got);
        bit st;
        bit err;
        int nst;
        logic [31:0] exp_ld;
        st = (o >= 3'd5);
`ifdef ADDR_ALIGN_CHECK_EN
        err = misaligned(o, a);
`else
        err = 1'b0;
`endif
        exp_ld = exp_load(d, o, a);
        nst = err ? 1 : (st ? 2 : 2 + lat(d));
        got = 'x;
        @(posedge clk); #1;
        req[d] = 1'b1; op[d] = o; addr[d] = a; wdata[d] = wd;
        #1;
        for (int k = 0; k <= nst; k++) begin
            if (k > 0) begin @(posedge clk); #2; end
            ncmp++;
            if (stall[d] !== (k < nst)) begin
                nerr++;
                $display("FAIL stall dut%0d op%0d a=%h k%0d: got %b want %b", d, o, a, k, stall[d], k < nst);
            end
            if (k > 0 && k < nst) begin
                ncmp++;
                if (ce[d] !== CHIP_ENABLE || sel[d] !== exp_sel(o, a) ||
                    raddr[d] !== {a[31:2], 2'b00} || we[d] !== (st && k == 1)) begin
                    nerr++;
                    $display("FAIL ram_drive dut%0d op%0d k%0d: got ce=%0d sel=%b addr=%h we=%b want ce=1 sel=%b addr=%h we=%b",
                             d, o, k, ce[d], sel[d], raddr[d], we[d], exp_sel(o, a), {a[31:2], 2'b00}, st && k == 1);
                end
                if (st && k == 1) begin
                    ncmp++;
                    if (rdo[d] !== exp_rdo(o, wd)) begin
                        nerr++;
                        $display("FAIL ram_data dut%0d op%0d: got %h want %h", d, o, rdo[d], exp_rdo(o, wd));
                    end
                end
            end else begin
                ncmp++;
                if (ce[d] !== CHIP_DISABLE || we[d] !== 1'b0) begin
                    nerr++;
                    $display("FAIL ram_idle dut%0d op%0d k%0d: got ce=%0d we=%b want ce=0 we=0", d, o, k, ce[d], we[d]);
                end
            end
            if (k == nst) begin
                ncmp++;
                if (lvalid[d] !== (!st && !err)) begin
                    nerr++;
                    $display("FAIL load_valid dut%0d op%0d: got %b want %b", d, o, lvalid[d], !st && !err);
                end
                ncmp++;
                if (aerr[d] !== err) begin
                    nerr++;
                    $display("FAIL addr_err dut%0d op%0d a=%h: got %b want %b", d, o, a, aerr[d], err);
                end
                if (err) begin
                    ncmp++;
                    if (bva[d] !== a) begin
                        nerr++;
                        $display("FAIL badvaddr dut%0d: got %h want %h", d, bva[d], a);
                    end
                end
                if (!st && !err) begin
                    got = ldata[d];
                    ncmp++;
                    if (ldata[d] !== exp_ld) begin
                        nerr++;
                        $display("FAIL load_data dut%0d op%0d a=%h: got %h want %h", d, o, a, ldata[d], exp_ld);
                    end
                end
            end else begin
                ncmp++;
                if (lvalid[d] !== 1'b0) begin
                    nerr++;
                    $display("FAIL early_valid dut%0d op%0d k%0d: got %b want 0", d, o, k, lvalid[d]);
                end
            end
        end
        if (st && !err) model_store(d, o, a, wd);
    endtask

    task automatic idle_all(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) req[d] = 1'b0;
            #1;
            for (int d = 0; d < 2; d++) begin
                ncmp++;
                if (stall[d] !== 1'b0 || lvalid[d] !== 1'b0 || aerr[d] !== 1'b0) begin
                    nerr++;
                    $display("FAIL idle dut%0d: got stall=%b valid=%b err=%b want 0 0 0", d, stall[d], lvalid[d], aerr[d]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req[0] = 1'b1; op[0] = 3'd7; addr[0] = 32'h100; wdata[0] = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            ncmp++;
            if (stall[d] !== 1'b0 || ce[d] !== CHIP_DISABLE || we[d] !== 1'b0 || sel[d] !== 4'd0) begin
                nerr++;
                $display("FAIL reset_ctl dut%0d: got stall=%b ce=%0d we=%b sel=%b want 0 0 0 0", d, stall[d], ce[d], we[d], sel[d]);
            end
            ncmp++;
            if (raddr[d] !== 32'd0 || rdo[d] !== 32'd0 || ldata[d] !== 32'd0 || bva[d] !== 32'd0) begin
                nerr++;
                $display("FAIL reset_data dut%0d: got addr=%h wd=%h ld=%h bva=%h want all 0", d, raddr[d], rdo[d], ldata[d], bva[d]);
            end
            ncmp++;
            if (lvalid[d] !== 1'b0 || aerr[d] !== 1'b0) begin
                nerr++;
                $display("FAIL reset_pulse dut%0d: got valid=%b err=%b want 0 0", d, lvalid[d], aerr[d]);
            end
        end
        req[0] = 1'b0;
        #1 rst_n = 1'b1;
        idle_all(2);
    endtask

    task automatic test_directed();
        logic [31:0] g;
        for (int d = 0; d < 2; d++) begin
            do_txn(d, 3'd7, 32'h100, 32'h1122_3344, g);
            do_txn(d, 3'd5, 32'h103, 32'h0000_00AB, g);
            do_txn(d, 3'd0, 32'h103, 32'h0, g);
            ncmp++;
            if (g !== 32'hFFFF_FFAB) begin nerr++; $display("FAIL lb_lit dut%0d: got %h want ffffffab", d, g); end
            do_txn(d, 3'd1, 32'h103, 32'h0, g);
            ncmp++;
            if (g !== 32'h0000_00AB) begin nerr++; $display("FAIL lbu_lit dut%0d: got %h want 000000ab", d, g); end
            do_txn(d, 3'd7, 32'h100, 32'h1234_8001, g);
            do_txn(d, 3'd2, 32'h102, 32'h0, g);
            ncmp++;
            if (g !== 32'hFFFF_8001) begin nerr++; $display("FAIL lh_lit dut%0d: got %h want ffff8001", d, g); end
            do_txn(d, 3'd3, 32'h100, 32'h0, g);
            ncmp++;
            if (g !== 32'h0000_1234) begin nerr++; $display("FAIL lhu_lit dut%0d: got %h want 00001234", d, g); end
            idle_all(1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] g;
        logic [31:0] v;
        for (int d = 0; d < 2; d++) begin
            v = $urandom;
            do_txn(d, 3'd7, 32'h0, v, g);
            do_txn(d, 3'd4, 32'h0, 32'h0, g);
            ncmp++;
            if (g !== v) begin nerr++; $display("FAIL b2b dut%0d: got %h want %h", d, g, v); end
            idle_all(1);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] g;
        for (int d = 0; d < 2; d++) begin
            do_txn(d, 3'd4, 32'h102, 32'h0, g);
`ifndef ADDR_ALIGN_CHECK_EN
            ncmp++;
            if (g !== 32'h1234_8001) begin nerr++; $display("FAIL lw_unaligned dut%0d: got %h want 12348001", d, g); end
`endif
            do_txn(d, 3'd3, 32'h101, 32'h0, g);
            do_txn(d, 3'd6, 32'h203, $urandom, g);
            do_txn(d, 3'd7, 32'h301, $urandom, g);
            do_txn(d, 3'd4, 32'h300, 32'h0, g);
            idle_all(1);
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] g;
        @(posedge clk); #1;
        req[1] = 1'b1; op[1] = 3'd4; addr[1] = 32'h200;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        ncmp++;
        if (ce[1] !== CHIP_DISABLE || stall[1] !== 1'b0 || lvalid[1] !== 1'b0 || sel[1] !== 4'd0) begin
            nerr++;
            $display("FAIL rst_wait dut1: got ce=%0d stall=%b valid=%b sel=%b want 0 0 0 0", ce[1], stall[1], lvalid[1], sel[1]);
        end
        req[1] = 1'b0;
        @(posedge clk); #2;
        ncmp++;
        if (lvalid[1] !== 1'b0 || stall[1] !== 1'b0) begin
            nerr++;
            $display("FAIL rst_hold dut1: got valid=%b stall=%b want 0 0", lvalid[1], stall[1]);
        end
        #2 rst_n = 1'b1;
        do_txn(1, 3'd4, 32'h200, 32'h0, g);
        idle_all(1);
    endtask

    task automatic test_reset_store();
        logic [31:0] g;
        logic [7:0]  old;
        old = bmem[0][64];
        @(posedge clk); #1;
        req[0] = 1'b1; op[0] = 3'd5; addr[0] = 32'h40; wdata[0] = {24'd0, ~old};
        #2 rst_n = 1'b0;
        #1;
        ncmp++;
        if (stall[0] !== 1'b0) begin nerr++; $display("FAIL rst_stall dut0: got %b want 0", stall[0]); end
        @(posedge clk); #2;
        req[0] = 1'b0;
        rst_n = 1'b1;
        do_txn(0, 3'd1, 32'h40, 32'h0, g);
        ncmp++;
        if (g !== {24'd0, old}) begin nerr++; $display("FAIL rst_nowrite dut0: got %h want %h", g, {24'd0, old}); end
        idle_all(1);
    endtask

    task automatic test_random();
        logic [31:0] g;
        logic [31:0] a;
        logic [2:0]  o;
        for (int d = 0; d < 2; d++) begin
            repeat (40) begin
                o = 3'($urandom_range(0, 7));
                a = $urandom;
                a[9:0] = 10'($urandom_range(0, 15));
                do_txn(d, o, a, $urandom, g);
                if ($urandom_range(0, 2) == 0) idle_all(1);
            end
            idle_all(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; op[d] = 3'd0; addr[d] = 32'd0; wdata[d] = 32'd0;
            for (int i = 0; i < 1024; i++) begin
                w = init_word(d, i / 4) >> (8 * (3 - (i % 4)));
                bmem[d][i] = w[7:0];
            end
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_misaligned();
        test_reset_wait();
        test_reset_store();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

`default_nettype wire
